// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and round functions for the SHA-256 engine.
// Latency: n/a (package). Backpressure: n/a.
// Contents: word/hash/schedule/working-state types, FSM state enum, IV[0:7],
//           K[0:63], and the SHA-256 functions big/small sigma, ch, maj.
package sha256_pkg;

  typedef logic [31:0]       word_t;
  // Index 0 is the most significant word, so H0 / W0 sit at the top of the vector.
  typedef logic [0:7][31:0]  hash_t;
  typedef logic [0:15][31:0] sched_t;

  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } work_t;

  typedef enum logic [2:0] {IDLE, RND0, FIN0, RND1, FIN1, DONE} state_t;

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one SHA-256 compression round, purely combinational.
// Latency: 0 cycles. Backpressure: none (no handshake).
// Ports: s = working vars a..h, w = schedule word Wt, k = round constant Kt,
//        s_next = working vars after the round.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       s,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output work_t       s_next
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
    t2 = big_sigma0(s.a) + maj(s.a, s.b, s.c);
    s_next.a = t1 + t2;
    s_next.b = s.a;
    s_next.c = s.b;
    s_next.d = s.c;
    s_next.e = s.d + t1;
    s_next.f = s.e;
    s_next.g = s.f;
    s_next.h = s.g;
  end

endmodule

// File: rtl/sha256_two_block.sv
// sha256_two_block: SHA-256 over one pre-padded two-block (1024-bit) message.
// Latency: accept to out_valid 131 cycles (67 with SHA256_UNROLL2_EN, two rounds/cycle).
// Backpressure: in_ready only in IDLE; digest held in DONE until out_ready.
// Ports: clk_i, rst_i (async, active-high); in_valid/in/in_ready message input
//        (in[1023:512] = block 0); out_valid/out/out_ready digest output (out[255:224] = H0).
// Macro: SHA256_UNROLL2_EN selects two chained rounds per cycle.
module sha256_two_block
  import sha256_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid,
  input  logic [1023:0] in,
  output logic          in_ready,
  output logic          out_valid,
  output logic [255:0]  out,
  input  logic          out_ready
);

  state_t       state;
  state_t       state_nxt;
  logic [5:0]   cnt;
  sched_t       w;         // w[0] is the word consumed by the current round
  logic [511:0] blk1;      // block 0 goes straight into w at accept; only block 1 waits here
  work_t        work;
  hash_t        hv;
  hash_t        work_h;
  hash_t        hsum;
  work_t        rnd_out;
  sched_t       w_adv;
  logic         last_rnd;
  work_t        r1;

  sha256_round u_rnd0 (
    .s      (work),
    .w      (w[0]),
    .k      (K[cnt]),
    .s_next (r1)
  );

`ifdef SHA256_UNROLL2_EN
  localparam logic [5:0] STEP = 6'd2;
  work_t r2;

  // Second round consumes the next schedule word with K[cnt+1]; cnt is always even here.
  sha256_round u_rnd1 (
    .s      (r1),
    .w      (w[1]),
    .k      (K[cnt + 6'd1]),
    .s_next (r2)
  );

  assign rnd_out  = r2;
  assign last_rnd = (cnt == 6'd62);

  // Window moves by two words: W[t+16] and W[t+17] are both formed from words still in the window.
  always_comb begin
    w_adv = '0;
    for (int i = 0; i < 14; i++) w_adv[i] = w[i+2];
    w_adv[14] = small_sigma1(w[14]) + w[9]  + small_sigma0(w[1]) + w[0];
    w_adv[15] = small_sigma1(w[15]) + w[10] + small_sigma0(w[2]) + w[1];
  end
`else
  localparam logic [5:0] STEP = 6'd1;

  assign rnd_out  = r1;
  assign last_rnd = (cnt == 6'd63);

  // Window moves by one word; new tail is W[t+16].
  always_comb begin
    w_adv = '0;
    for (int i = 0; i < 15; i++) w_adv[i] = w[i+1];
    w_adv[15] = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end
`endif

  // Per-word feed-forward add of the working variables into the chaining value.
  assign work_h = hash_t'(work);
  always_comb begin
    hsum = '0;
    for (int i = 0; i < 8; i++) hsum[i] = hv[i] + work_h[i];
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RND0;
      RND0:    if (last_rnd)  state_nxt = FIN0;
      FIN0:                   state_nxt = RND1;
      RND1:    if (last_rnd)  state_nxt = FIN1;
      FIN1:                   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs; in_ready is masked while reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && !rst_i;
    out_valid = (state == DONE);
  end

  // Datapath. cnt wraps to 0 on its own at the end of each block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      w    <= '0;
      blk1 <= '0;
      work <= '0;
      hv   <= '0;
      out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w    <= in[1023:512];
            blk1 <= in[511:0];
            work <= work_t'(IV);
            hv   <= IV;
            cnt  <= '0;
          end
        end
        RND0, RND1: begin
          work <= rnd_out;
          w    <= w_adv;
          cnt  <= cnt + STEP;
        end
        FIN0: begin
          hv   <= hsum;
          work <= work_t'(hsum);
          w    <= blk1;
        end
        FIN1: begin
          hv  <= hsum;
          out <= hsum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_two_block.sv
// tb_sha256_two_block: directed vectors against a plain-arithmetic SHA-256 model
// with a per-cycle compare process on in_ready/out_valid/out.
module tb_sha256_two_block;

`ifdef SHA256_UNROLL2_EN
  localparam int LAT       = 67;
  localparam int BUSY_WAIT = 45;
`else
  localparam int LAT       = 131;
  localparam int BUSY_WAIT = 90;
`endif

  localparam logic [255:0] IVM     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_STD = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [31:0] KM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [1023:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [255:0]  out_data;
  logic          out_ready = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int n_valid_cyc = 0;

  // Model state: busy until a due cycle, then holding a digest until consumed.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_due  = 0;
  logic [255:0] m_dig  = '0;
  logic [255:0] m_out  = '0;
  logic         e_ready;
  logic         e_valid;

  sha256_two_block dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .in_valid  (in_valid),
    .in        (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(20000 * 10);
    $display("FAIL watchdog: simulation still running after 20000 cycles, required to finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule array, then 64 rounds.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KM[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] digest2(input logic [1023:0] m);
    return compress(compress(IVM, m[1023:512]), m[511:0]);
  endfunction

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_out  = '0;
    end else if (m_busy && cyc == m_due) begin
      m_busy = 1'b0;
      m_done = 1'b1;
      m_out  = m_dig;
    end
    e_ready = !rst && !m_busy && !m_done;
    e_valid = !rst && m_done;
    chk("cyc_in_ready", 256'(in_ready), 256'(e_ready));
    chk("cyc_out_valid", 256'(out_valid), 256'(e_valid));
    chk("cyc_out", out_data, m_out);
    if (out_valid) n_valid_cyc++;
    if (!rst) begin
      if (e_ready && in_valid) begin
        m_busy = 1'b1;
        m_due  = cyc + LAT;
        m_dig  = digest2(in_data);
      end
      if (e_valid && out_ready) m_done = 1'b0;
    end
  end

  task automatic send(input logic [1023:0] m, output int acc);
    int n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_wait: in_ready 0 after %0d cycles, required 1", n);
    end
    in_valid = 1'b1;
    in_data  = m;
    acc      = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~m;   // message must already be registered
  endtask

  task automatic wait_valid(input string name, input int acc, output int lat);
    int n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      n_total++;
      $display("FAIL %s: out_valid 0 after %0d cycles, required 1", name, n);
    end
    lat = cyc - acc;
  endtask

  initial begin
    logic [447:0]  txt;
    logic [511:0]  abc_blk;
    logic [1023:0] std_msg, msg2, msg3;
    logic [255:0]  snap;
    int acc, lat, n0;

    txt     = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    std_msg = {txt, 8'h80, 56'h0, 448'h0, 64'h1c0};
    abc_blk = {24'h616263, 8'h80, 416'h0, 64'h18};
    msg2    = {abc_blk, {16{32'hdeadbeef}}};
    msg3    = {{8{64'h0123456789abcdef}}, {16{32'h5a5aa5a5}}};

    // Pin the model to published digests.
    chk("model_abc", compress(IVM, abc_blk), DIG_ABC);
    chk("model_std", digest2(std_msg), DIG_STD);

    // Reset values while rst is held.
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 256'(in_ready), '0);
    chk("rst_out_valid", 256'(out_valid), '0);
    chk("rst_out", out_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 256'(in_ready), 256'(1));

    // Standard vector with latency, then 20 cycles of backpressure.
    send(std_msg, acc);
    wait_valid("std_wait", acc, lat);
    chk("std_latency", 256'(lat), 256'(LAT));
    chk("std_digest", out_data, DIG_STD);
    snap = out_data;
    repeat (20) @(posedge clk); #1;
    chk("bp_out_valid", 256'(out_valid), 256'(1));
    chk("bp_out_stable", out_data, snap);
    chk("bp_in_ready", 256'(in_ready), '0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_consumed_in_ready", 256'(in_ready), 256'(1));
    chk("bp_consumed_out_valid", 256'(out_valid), '0);

    // Busy input: a second message offered during block 1 is ignored.
    send(std_msg, acc);
    repeat (BUSY_WAIT) @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = msg3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("busy_wait", acc, lat);
    chk("busy_latency", 256'(lat), 256'(LAT));
    chk("busy_digest", out_data, DIG_STD);
    @(posedge clk); #1;
    chk("pulse_out_valid", 256'(out_valid), '0);

    // Reset mid-hash: no digest, out cleared, then a clean restart.
    out_ready = 1'b0;
    send(std_msg, acc);
    repeat (39) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = n_valid_cyc;
    repeat (200) @(posedge clk); #1;
    chk("abort_no_valid", 256'(n_valid_cyc - n0), '0);
    chk("abort_out_zero", out_data, '0);
    out_ready = 1'b1;
    send(std_msg, acc);
    wait_valid("restart_wait", acc, lat);
    chk("restart_digest", out_data, DIG_STD);
    @(posedge clk); #1;

    // Back-to-back with out_ready tied high.
    n0 = n_valid_cyc;
    send(msg2, acc);
    send(msg3, acc);
    chk("b2b_spacing", 256'(in_ready), '0);
    wait_valid("b2b_wait", acc, lat);
    chk("b2b_latency", 256'(lat), 256'(LAT));
    chk("b2b_digest2", out_data, digest2(msg3));
    repeat (3) @(posedge clk); #1;
    chk("b2b_valid_cycles", 256'(n_valid_cyc - n0), 256'(2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
